addsub_nibble_scheduler: RTL and testbench
==========================================

# addsub_nibble_scheduler

Sequencer and two-port arbiter that shares one external 4-bit adder/subtractor slice between two requesters. Each accepted request is a WIDTH-bit add or subtract, executed nibble-serially, least-significant nibble first, through the shared slice. The block sits between the requesting datapaths and the 4-bit adder-cum-subtractor. It drives the slice's x, z and cin inputs and captures its sum and carry outputs every cycle.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4; N = WIDTH/4 nibbles.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqK_valid (K=0,1)  in  1  request K presents an operation.
- reqK_ready  out  1  request K accepted this cycle when high together with reqK_valid.
- reqK_a, reqK_b  in  WIDTH  operands.
- reqK_sub  in  1  0 = a+b, 1 = a−b.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  index of the requester that owns the result.
- resp_result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- resp_carry  out  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned).
- alu_x, alu_z  out  4  nibble operands to the slice.
- alu_cin  out  1  slice cin; the slice internally XORs z with cin before adding cin.
- alu_sum  in  4  slice sum output, combinational from alu_x/alu_z/alu_cin.
- alu_carry  in  1  slice carry output, combinational.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - Arbitration: if exactly one reqK_valid is high, grant K. If both are high, grant the requester not granted last (round-robin).
  - reqK_ready = reqK_valid & grant==K, combinational; never high outside IDLE.
  - On handshake: latch a, b, sub and id; set nibble index i=0 and carry c=sub; update the last-grant register; go to RUN.
- RUN, one nibble per cycle:
  - alu_x = a[4i+3:4i]
  - alu_z = b[4i+3:4i] ^ {4{sub ^ c}}
  - alu_cin = c
  - This pre-inversion makes the slice compute a_i + (sub ? ~b_i : b_i) + c for every nibble.
  - On each edge: store alu_sum into result[4i+3:4i], set c = alu_carry, then i++.
  - After nibble N−1: resp_carry = last alu_carry; go to DONE.
- DONE
  - resp_valid = 1. resp_id, resp_result and resp_carry are held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Outside RUN, alu_x, alu_z and alu_cin are driven to 0.
- Reset value of every output, and of all internal state, is 0. Exception: the last-grant register resets to 1, so req0 wins the first tie.
- rst asserted in any state, including mid-RUN, aborts the operation. No response is produced for an aborted operation.

## Timing
- Request handshake at edge T. Nibble j is computed during cycle T+1+j. resp_valid rises after edge T+N (T+4 for WIDTH=16).
- Minimum initiation interval is N+2 cycles (RUN, DONE, IDLE) when resp_ready is held high.
- The alu_* outputs are registered-state decodes with no combinational path from the req* inputs. The slice's combinational path alu_x → alu_sum must close within one cycle.
- Backpressure: resp_ready low holds DONE indefinitely; reqK_ready stays low throughout.

## Configuration
- ADDSUB_SCHED_OVF_EN defined:
  - Adds output resp_overflow (1 bit, reset 0) giving the signed two's-complement overflow of the operation.
  - resp_overflow = (a[W−1] == beff[W−1]) & (result[W−1] != a[W−1]), where beff = sub ? ~b : b.
  - Registered at the end of RUN and held through DONE.
- ADDSUB_SCHED_OVF_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, req0 0x1234 + 0x0FCD → resp_result 0x2201, resp_carry 0, resp_id 0, resp_valid asserted 4 cycles after the handshake.
- req1 0x1234 − 0x0FCD → 0x0267, carry 1. Then 0x0001 − 0x0002 → 0xFFFF, carry 0.
- After reset, req0 and req1 both valid with resp_ready=1 → req0 served first (id 0), then req1 (id 1). A third tie is granted to req0.
- resp_ready held low for 3 cycles in DONE → result, id and carry are stable; both reqK_ready stay 0; exactly one response handshake follows.
- rst pulsed during the 2nd RUN cycle → all outputs 0 next cycle, no resp_valid produced. The next request completes correctly.
- With ADDSUB_SCHED_OVF_EN: 0x7FFF + 0x0001 → 0x8000, overflow 1, carry 0. 0x8000 − 0x0001 → 0x7FFF, overflow 1, carry 1.

Source files
------------

// File: rtl/addsub_nibble_scheduler_if.sv
// addsub_nibble_scheduler_if
// Request/response bus between two requesting datapaths (plus the result
// consumer) and the nibble-serial add/subtract scheduler.
//   req0_*/req1_* : valid/ready handshake with operands a, b and sub flag
//   resp_*        : valid/ready result channel with id, result and carry
// Modports:
//   master : requester/consumer side (drives requests and resp_ready)
//   slave  : scheduler side (drives req readies and the response)
interface addsub_nibble_scheduler_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_carry;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_carry,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_carry,
        input  resp_ready
    );
endinterface

// File: rtl/addsub_nibble_scheduler.sv
// addsub_nibble_scheduler
// Shares one external 4-bit adder/subtractor slice between two requesters.
// Each accepted request is a WIDTH-bit add or subtract executed nibble-serially,
// least-significant nibble first, one nibble per cycle through the slice.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : two request channels and one response channel
//   alu_x/alu_z  : nibble operands to the slice (0 outside RUN)
//   alu_cin      : carry into the slice (0 outside RUN)
//   alu_sum      : slice sum, combinational from alu_x/alu_z/alu_cin
//   alu_carry    : slice carry out, combinational
//   resp_overflow: signed overflow of the result (only with ADDSUB_SCHED_OVF_EN)
// Optional feature macro: ADDSUB_SCHED_OVF_EN adds the resp_overflow output.
// WIDTH must be a multiple of 4 and at least 4.
module addsub_nibble_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    addsub_nibble_scheduler_if.slave      bus,
    output logic [3:0]                    alu_x,
    output logic [3:0]                    alu_z,
    output logic                          alu_cin,
    input  logic [3:0]                    alu_sum,
    input  logic                          alu_carry
`ifdef ADDSUB_SCHED_OVF_EN
    ,
    output logic                          resp_overflow
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic             id_r;
    logic [IW-1:0]    idx_r;
    logic             c_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             last_grant_r;

    logic             grant_s;
    logic             hs_s;
    logic             ready0_s;
    logic             ready1_s;
    logic             resp_valid_s;
    logic [3:0]       alu_x_s;
    logic [3:0]       alu_z_s;
    logic             alu_cin_s;

`ifdef ADDSUB_SCHED_OVF_EN
    logic             ovf_r;

    // Signed overflow: operand signs agree (after optional inversion of b) and result sign differs.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic sub, input logic sum_msb);
        logic beff_msb;
        beff_msb = b_msb ^ sub;
        return (a_msb == beff_msb) & (sum_msb != a_msb);
    endfunction
`endif

    // Round-robin arbitration: a tie goes to the requester not granted last.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign hs_s = (bus.req0_valid & ready0_s) | (bus.req1_valid & ready1_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode. The z operand is pre-inverted by (sub ^ c) because the
    // slice XORs z with cin internally; the net effect is a + (sub ? ~b : b) + c.
    always_comb begin
        ready0_s     = 1'b0;
        ready1_s     = 1'b0;
        resp_valid_s = 1'b0;
        alu_x_s      = 4'h0;
        alu_z_s      = 4'h0;
        alu_cin_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready0_s = bus.req0_valid & ~grant_s;
                ready1_s = bus.req1_valid & grant_s;
            end
            ST_RUN: begin
                alu_x_s   = a_r[{idx_r, 2'b00} +: 4];
                alu_z_s   = b_r[{idx_r, 2'b00} +: 4] ^ {4{sub_r ^ c_r}};
                alu_cin_s = c_r;
            end
            ST_DONE: begin
                resp_valid_s = 1'b1;
            end
            default: begin
                resp_valid_s = 1'b0;
            end
        endcase
    end

    // Operand capture at handshake, nibble-serial accumulation during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r          <= '0;
            b_r          <= '0;
            sub_r        <= 1'b0;
            id_r         <= 1'b0;
            idx_r        <= '0;
            c_r          <= 1'b0;
            result_r     <= '0;
            carry_r      <= 1'b0;
            last_grant_r <= 1'b1;
`ifdef ADDSUB_SCHED_OVF_EN
            ovf_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        a_r          <= grant_s ? bus.req1_a   : bus.req0_a;
                        b_r          <= grant_s ? bus.req1_b   : bus.req0_b;
                        sub_r        <= grant_s ? bus.req1_sub : bus.req0_sub;
                        c_r          <= grant_s ? bus.req1_sub : bus.req0_sub;
                        id_r         <= grant_s;
                        idx_r        <= '0;
                        last_grant_r <= grant_s;
                    end
                end
                ST_RUN: begin
                    result_r[{idx_r, 2'b00} +: 4] <= alu_sum;
                    c_r   <= alu_carry;
                    idx_r <= idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        carry_r <= alu_carry;
`ifdef ADDSUB_SCHED_OVF_EN
                        ovf_r   <= ovf_calc(a_r[WIDTH-1], b_r[WIDTH-1], sub_r, alu_sum[3]);
`endif
                    end
                end
                default: begin
                    c_r <= c_r;
                end
            endcase
        end
    end

    assign bus.req0_ready  = ready0_s;
    assign bus.req1_ready  = ready1_s;
    assign bus.resp_valid  = resp_valid_s;
    assign bus.resp_id     = id_r;
    assign bus.resp_result = result_r;
    assign bus.resp_carry  = carry_r;
    assign alu_x           = alu_x_s;
    assign alu_z           = alu_z_s;
    assign alu_cin         = alu_cin_s;
`ifdef ADDSUB_SCHED_OVF_EN
    assign resp_overflow   = ovf_r;
`endif

endmodule

// File: tb/tb_addsub_nibble_scheduler.sv
// tb_addsub_nibble_scheduler
// Scoreboard bench: drivers push the hand-computed expected response when a
// request handshake happens; a monitor pops and compares on every response
// handshake. Includes a behavioural model of the external 4-bit slice.
// Define ADDSUB_SCHED_OVF_EN to also check resp_overflow.
module tb_addsub_nibble_scheduler;
    localparam int W = 16;

    logic clk;
    logic rst;
    logic [3:0] alu_x;
    logic [3:0] alu_z;
    logic       alu_cin;
    logic [3:0] alu_sum;
    logic       alu_carry;
`ifdef ADDSUB_SCHED_OVF_EN
    logic       resp_overflow;
`endif

    addsub_nibble_scheduler_if #(.WIDTH(W)) bus ();

    addsub_nibble_scheduler #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_x     (alu_x),
        .alu_z     (alu_z),
        .alu_cin   (alu_cin),
        .alu_sum   (alu_sum),
        .alu_carry (alu_carry)
`ifdef ADDSUB_SCHED_OVF_EN
        ,
        .resp_overflow (resp_overflow)
`endif
    );

    // External slice: z is XORed with cin internally, then cin is added.
    always_comb begin
        {alu_carry, alu_sum} = {1'b0, alu_x} + {1'b0, alu_z ^ {4{alu_cin}}} + {4'b0000, alu_cin};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        int           hs_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend[2];
    bit   pend_push[2];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   pushed = 0;
    int   popped = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency check on the rising edge of resp_valid, data check on handshake.
    initial begin : monitor
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1 && prev_v == 1'b0 && sb_q.size() > 0) begin
                chk("resp_latency", cyc - sb_q[0].hs_cyc, 32'd4);
            end
            if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    popped++;
                    chk("resp_id",     {31'd0, bus.resp_id},    {31'd0, e.id});
                    chk("resp_result", {16'd0, bus.resp_result}, {16'd0, e.res});
                    chk("resp_carry",  {31'd0, bus.resp_carry}, {31'd0, e.carry});
`ifdef ADDSUB_SCHED_OVF_EN
                    chk("resp_overflow", {31'd0, resp_overflow}, {31'd0, e.ovf});
`endif
                end
            end
            prev_v = bus.resp_valid;
        end
    end

    // Present a request on port k (caller aligns to posedge + #1).
    task automatic post(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] r, input logic c, input logic o, input bit push);
        pend[k].id     = (k == 1);
        pend[k].res    = r;
        pend[k].carry  = c;
        pend[k].ovf    = o;
        pend[k].hs_cyc = 0;
        pend_push[k]   = push;
        if (k == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end
    endtask

    // Wait (bounded) for a request handshake; returns the accepted port.
    task automatic accept(output int who);
        who = -1;
        for (int n = 0; n < 64 && who < 0; n++) begin
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready) who = 0;
            else if (bus.req1_valid && bus.req1_ready) who = 1;
        end
        if (who < 0) begin
            chk("accept_timeout", 32'd1, 32'd0);
            @(posedge clk); #1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end else begin
            pend[who].hs_cyc = cyc + 1;
            if (pend_push[who]) begin
                sb_q.push_back(pend[who]);
                pushed++;
            end
            @(posedge clk); #1;
            if (who == 0) bus.req0_valid = 1'b0;
            else          bus.req1_valid = 1'b0;
        end
    endtask

    task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] r, input logic c, input logic o);
        int who;
        @(posedge clk); #1;
        post(k, a, b, sub, r, c, o, 1'b1);
        accept(who);
        chk("grant_port", who, k);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.resp_valid === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int who;
        int pop_before;
        bit seen;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_resp_valid",  {31'd0, bus.resp_valid},   32'd0);
        chk("rst_resp_result", {16'd0, bus.resp_result},  32'd0);
        chk("rst_resp_carry",  {31'd0, bus.resp_carry},   32'd0);
        chk("rst_resp_id",     {31'd0, bus.resp_id},      32'd0);
        chk("rst_alu",         {23'd0, alu_x, alu_z, alu_cin}, 32'd0);
`ifdef ADDSUB_SCHED_OVF_EN
        chk("rst_overflow",    {31'd0, resp_overflow},    32'd0);
`endif

        // Directed add/subtract vectors
        issue(0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        issue(1, 16'h1234, 16'h0FCD, 1'b1, 16'h0267, 1'b1, 1'b0);
        issue(1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0);
        issue(1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Round-robin ties after reset: req0, req1, then req0 again
        pulse_reset();
        @(posedge clk); #1;
        post(0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        post(1, 16'h5555, 16'h1111, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b1);
        accept(who); chk("tie1_first", who, 0);
        accept(who); chk("tie1_second", who, 1);
        drain();
        @(posedge clk); #1;
        post(0, 16'h0100, 16'h0100, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b1);
        post(1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        accept(who); chk("tie2_first", who, 0);
        accept(who); chk("tie2_second", who, 1);
        drain();

        // Backpressure: hold DONE for 3 cycles with req1 waiting
        bus.resp_ready = 1'b0;
        issue(0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) seen = 1'b1;
        end
        chk("bp_valid_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        post(1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("bp_hold_valid",  {31'd0, bus.resp_valid},  32'd1);
            chk("bp_hold_result", {16'd0, bus.resp_result}, 32'h3333);
            chk("bp_hold_id",     {31'd0, bus.resp_id},     32'd0);
            chk("bp_hold_carry",  {31'd0, bus.resp_carry},  32'd0);
            chk("bp_hold_ready",  {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        end
        pop_before = popped;
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        accept(who);
        chk("bp_next_grant", who, 1);
        chk("bp_one_handshake", popped - pop_before, 32'd1);
        drain();

        // Reset during the second RUN cycle aborts the operation
        @(posedge clk); #1;
        post(1, 16'h4321, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        accept(who);
        chk("abort_grant", who, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("abort_pre_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        chk("abort_resp_result", {16'd0, bus.resp_result}, 32'd0);
        chk("abort_resp_id",     {31'd0, bus.resp_id},     32'd0);
        chk("abort_resp_carry",  {31'd0, bus.resp_carry},  32'd0);
        chk("abort_alu",         {23'd0, alu_x, alu_z, alu_cin}, 32'd0);
`ifdef ADDSUB_SCHED_OVF_EN
        chk("abort_overflow",    {31'd0, resp_overflow},   32'd0);
`endif
        @(posedge clk); #1; rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_resp", {31'd0, seen}, 32'd0);
        issue(0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        drain();

        chk("resp_count", popped, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
